xvc_shift_sched: RTL
====================

// Module: xvc_shift_sched
// PURPOSE
//  Sequences one XVC "shift:" command over the 32-bit JTAG shift engine (jtag_proc) for arbitrary bit counts.
//  Splits N bits into <=32-bit chunks, fetches TMS/TDI words from the command buffers and launches one engine pass per chunk.
//  Masks and writes each TDO word back to the result buffer, then reports done or error to the AXI/register layer.
// PARAMETERS
//  ADDR_W      6     word address width of TMS/TDI/TDO buffers (2**ADDR_W words of 32 bits)
//  MAX_BITS    2048  largest legal cmd_nbits_i; must be <= 32*2**ADDR_W
//  TIMEOUT_CYC 4096  cycles allowed from engine launch to jp_done_i before error
// PORTS
//  clk_i        in   1       system clock
//  resetn_i     in   1       reset, asynchronous assert, active-low
//  cmd_valid_i  in   1       command request
//  cmd_ready_o  out  1       high only in IDLE; command accepted when valid&ready
//  cmd_nbits_i  in   16      bits to shift, legal 1..MAX_BITS
//  abort_i      in   1       stop after the chunk in flight
//  busy_o       out  1       high from accept until done_o/err_o pulse (inclusive)
//  done_o       out  1       1-cycle pulse, command complete
//  err_o        out  1       1-cycle pulse, bad length or timeout
//  buf_rd_o     out  1       buffer read strobe; data valid exactly 1 cycle later
//  buf_addr_o   out  ADDR_W  word address, shared by TMS/TDI read and TDO write
//  tms_rdata_i  in   32      TMS word (bit0 shifted first)
//  tdi_rdata_i  in   32      TDI word (bit0 shifted first)
//  tdo_we_o     out  1       TDO word write strobe
//  tdo_wdata_o  out  32      TDO word, bit i = i-th captured bit
//  jp_en_o      out  1       engine launch (engine is rising-edge triggered)
//  jp_length_o  out  32      chunk length 1..32
//  jp_tms_o     out  32      chunk TMS vector
//  jp_tdi_o     out  32      chunk TDI vector
//  jp_done_i    in   1       engine done pulse
//  jp_tdo_i     in   32      engine TDO vector, valid on/after jp_done_i
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready_o=1; state IDLE; remaining/addr/watchdog counters 0.
//  States: IDLE -> RD -> RDW -> LAUNCH -> WAIT -> WR -> (RD | FIN) ; any -> ERR on fault.
//   IDLE: on valid&ready, latch nbits into rem (16b). nbits==0 or >MAX_BITS -> ERR; else addr=0, go RD.
//   RD: buf_rd_o=1 for 1 cycle. RDW: capture tms/tdi into jp_tms_o/jp_tdi_o registers.
//    jp_length_o = (rem>=32) ? 32 : rem.
//   LAUNCH: jp_en_o=1 for exactly 1 cycle; vectors/length stable from RDW until WR.
//    jp_en_o is low >=1 cycle between launches.
//   WAIT: watchdog counts from 0; jp_done_i -> WR; count==TIMEOUT_CYC-1 with no done -> ERR.
//   WR: tdo_we_o=1 one cycle at buf_addr_o=addr, data=jp_tdo_i & ((1<<len)-1) (len=32 -> all ones).
//    rem-=len, addr+=1. rem==0 or abort latched -> FIN; else RD.
//   FIN: done_o=1 for one cycle -> IDLE. ERR: err_o=1 for one cycle -> IDLE.
//  abort_i: sticky flag, cleared in IDLE; never cuts a chunk in flight (engine cannot be stopped).
//   Abort in IDLE is ignored. Abort on an accept cycle aborts after chunk 0.
//  Latency, 1 full chunk: accept -> jp_en_o = 3 cycles; jp_done_i -> tdo_we_o = 1 cycle; last WR -> done_o = 1 cycle.
//  cmd_valid_i while busy: ignored, not queued. jp_done_i outside WAIT: ignored.
//  Reset mid-command: immediate return to IDLE, no further writes.
//   Engine may still finish its pass; the stray done is ignored.
//  addr never wraps for legal lengths (MAX_BITS bound); rem arithmetic unsigned, never underflows.
// STRUCTURE
//  xvc_pkg: state localparams (one-hot, 8 states), WORD_W=32, LEN_W=16.
//   Also a mask function word_mask(len) -> 32b.
//  Flat module, no sub-modules; instantiated beside jtag_proc in the XVC top, buffers external.
// TESTING
//  nbits=32, TMS=0x0000_0001, TDI=0xA5A5_A5A5, TDO model returns 0xDEAD_BEEF
//   -> 1 launch, jp_length_o=32, tdo word0=0xDEAD_BEEF, done_o pulse, busy_o low next cycle.
//  nbits=70 -> 3 launches with lengths 32,32,6; addr 0,1,2.
//   Word2 = model & 0x3F; en low between launches.
//  nbits=0 and nbits=2049 -> err_o pulse 1 cycle after accept; no buf_rd_o, jp_en_o or tdo_we_o.
//  Model never asserts done -> err_o exactly TIMEOUT_CYC cycles after the WAIT entry; cmd_ready_o back to 1.
//  nbits=96, abort_i pulsed during chunk0 WAIT -> chunk0 written, done_o, no chunk1 launch.
//   New command accepted afterwards runs in full.
//  resetn_i low mid-WAIT (async, off clock edge) -> outputs at reset values immediately.
//   A later jp_done_i is ignored, with no tdo_we_o.

Source files
------------

// File: rtl/xvc_shift_sched_pkg.sv
// Shared types and helpers for the XVC shift scheduler.
// The state encoding is one-hot. word_mask keeps the low len bits of a TDO word.
package xvc_shift_sched_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int CLEN_W = 6;   // chunk length 0..32

  typedef enum logic [7:0] {
    S_IDLE   = 8'b0000_0001,
    S_RD     = 8'b0000_0010,
    S_RDW    = 8'b0000_0100,
    S_LAUNCH = 8'b0000_1000,
    S_WAIT   = 8'b0001_0000,
    S_WR     = 8'b0010_0000,
    S_FIN    = 8'b0100_0000,
    S_ERR    = 8'b1000_0000
  } state_t;

  function automatic logic [WORD_W-1:0] word_mask(input logic [CLEN_W-1:0] len);
    logic [WORD_W-1:0] m;
    if (len >= CLEN_W'(WORD_W)) begin
      m = '1;
    end else begin
      m = (WORD_W'(1) << len) - WORD_W'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/xvc_shift_sched_if.sv
// Command, buffer and JTAG-engine signals of the XVC shift scheduler.
// master is the scheduler side; slave is the register layer, buffers and engine.
interface xvc_shift_sched_if #(
  parameter int ADDR_W = 6
);

  logic                                   cmd_valid_i;
  logic                                   cmd_ready_o;
  logic [xvc_shift_sched_pkg::LEN_W-1:0]  cmd_nbits_i;
  logic                                   abort_i;
  logic                                   busy_o;
  logic                                   done_o;
  logic                                   err_o;

  logic                                   buf_rd_o;
  logic [ADDR_W-1:0]                      buf_addr_o;
  logic [xvc_shift_sched_pkg::WORD_W-1:0] tms_rdata_i;
  logic [xvc_shift_sched_pkg::WORD_W-1:0] tdi_rdata_i;
  logic                                   tdo_we_o;
  logic [xvc_shift_sched_pkg::WORD_W-1:0] tdo_wdata_o;

  logic                                   jp_en_o;
  logic [xvc_shift_sched_pkg::WORD_W-1:0] jp_length_o;
  logic [xvc_shift_sched_pkg::WORD_W-1:0] jp_tms_o;
  logic [xvc_shift_sched_pkg::WORD_W-1:0] jp_tdi_o;
  logic                                   jp_done_i;
  logic [xvc_shift_sched_pkg::WORD_W-1:0] jp_tdo_i;

  modport master (
    input  cmd_valid_i, cmd_nbits_i, abort_i,
    output cmd_ready_o, busy_o, done_o, err_o,
    output buf_rd_o, buf_addr_o, tdo_we_o, tdo_wdata_o,
    input  tms_rdata_i, tdi_rdata_i,
    output jp_en_o, jp_length_o, jp_tms_o, jp_tdi_o,
    input  jp_done_i, jp_tdo_i
  );

  modport slave (
    output cmd_valid_i, cmd_nbits_i, abort_i,
    input  cmd_ready_o, busy_o, done_o, err_o,
    input  buf_rd_o, buf_addr_o, tdo_we_o, tdo_wdata_o,
    output tms_rdata_i, tdi_rdata_i,
    input  jp_en_o, jp_length_o, jp_tms_o, jp_tdi_o,
    output jp_done_i, jp_tdo_i
  );

endinterface

// File: rtl/xvc_shift_sched.sv
// Runs one XVC shift command as a sequence of <=32-bit passes of the JTAG engine,
// fetching TMS/TDI words per chunk and writing the masked TDO word back.
module xvc_shift_sched
  import xvc_shift_sched_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int MAX_BITS    = 2048,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  xvc_shift_sched_if.master   bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  state_t              state_reg,  state_next;
  logic [LEN_W-1:0]    rem_reg,    rem_next;
  logic [ADDR_W-1:0]   addr_reg,   addr_next;
  logic [WD_W-1:0]     wd_reg,     wd_next;
  logic                abort_reg,  abort_next;
  logic [CLEN_W-1:0]   len_reg,    len_next;
  logic [WORD_W-1:0]   tms_reg,    tms_next;
  logic [WORD_W-1:0]   tdi_reg,    tdi_next;
  logic [WORD_W-1:0]   tdo_reg,    tdo_next;

  logic [LEN_W-1:0]    rem_after;
  logic                bad_len;

  assign rem_after = rem_reg - LEN_W'(len_reg);
  assign bad_len   = (bus.cmd_nbits_i == '0) || (bus.cmd_nbits_i > LEN_W'(MAX_BITS));

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rem_reg   <= '0;
      addr_reg  <= '0;
      wd_reg    <= '0;
      abort_reg <= 1'b0;
      len_reg   <= '0;
      tms_reg   <= '0;
      tdi_reg   <= '0;
      tdo_reg   <= '0;
    end else begin
      rem_reg   <= rem_next;
      addr_reg  <= addr_next;
      wd_reg    <= wd_next;
      abort_reg <= abort_next;
      len_reg   <= len_next;
      tms_reg   <= tms_next;
      tdi_reg   <= tdi_next;
      tdo_reg   <= tdo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    addr_next  = addr_reg;
    wd_next    = wd_reg;
    abort_next = abort_reg;
    len_next   = len_reg;
    tms_next   = tms_reg;
    tdi_next   = tdi_reg;
    tdo_next   = tdo_reg;

    // Abort is only a request: the chunk in flight always completes.
    if (state_reg != S_IDLE && bus.abort_i) begin
      abort_next = 1'b1;
    end

    unique case (state_reg)
      S_IDLE: begin
        abort_next = 1'b0;
        if (bus.cmd_valid_i) begin
          rem_next   = bus.cmd_nbits_i;
          addr_next  = '0;
          abort_next = bus.abort_i;
          state_next = bad_len ? S_ERR : S_RD;
        end
      end
      S_RD: begin
        state_next = S_RDW;
      end
      S_RDW: begin
        tms_next   = bus.tms_rdata_i;
        tdi_next   = bus.tdi_rdata_i;
        len_next   = (rem_reg >= LEN_W'(WORD_W)) ? CLEN_W'(WORD_W) : rem_reg[CLEN_W-1:0];
        state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        wd_next    = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.jp_done_i) begin
          tdo_next   = bus.jp_tdo_i & word_mask(len_reg);
          state_next = S_WR;
        end else if (wd_reg == WD_W'(TIMEOUT_CYC - 1)) begin
          state_next = S_ERR;
        end else begin
          wd_next = wd_reg + WD_W'(1);
        end
      end
      S_WR: begin
        rem_next   = rem_after;
        addr_next  = addr_reg + ADDR_W'(1);
        state_next = (rem_after == '0 || abort_next) ? S_FIN : S_RD;
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      S_ERR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the one-hot state, so an async reset clears them at once.
  assign bus.cmd_ready_o = (state_reg == S_IDLE);
  assign bus.busy_o      = (state_reg != S_IDLE);
  assign bus.buf_rd_o    = (state_reg == S_RD);
  assign bus.buf_addr_o  = addr_reg;
  assign bus.tdo_we_o    = (state_reg == S_WR);
  assign bus.tdo_wdata_o = (state_reg == S_WR) ? tdo_reg : '0;
  assign bus.jp_en_o     = (state_reg == S_LAUNCH);
  assign bus.jp_length_o = WORD_W'(len_reg);
  assign bus.jp_tms_o    = tms_reg;
  assign bus.jp_tdi_o    = tdi_reg;
  assign bus.done_o      = (state_reg == S_FIN);
  assign bus.err_o       = (state_reg == S_ERR);

endmodule
